verificador_jogada_n: RTL

Parametrised move-verification engine for the Sudoku game datapath, sitting between the move-entry registers (row/column/value) and the player-board register. It validates a requested move against coordinates, value range and the fixed-cell mask, then checks it against the solution. Correct moves are written back through a one-cycle write strobe. A multi-cycle row-by-row scan detects a finished board, and an error counter grants a configurable number of lives before the game is lost.

---
 rtl/verificador_jogada_n.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/verificador_jogada_n.sv
// -----------------------------------------------------------------------------
// verificador_jogada_n
//
// Sudoku move-verification engine. It sits between the move-entry registers
// and the player-board register. One requested move is checked for legal
// coordinates, legal value and the fixed-cell mask, and then against the
// solution. A correct move is written back with a one-cycle strobe, and a
// row-per-cycle scan then decides whether the board is finished. Wrong moves
// spend lives. After a win or a loss the engine locks until novoJogo or reset.
//
// Parameters
//   N         grid side (2..15), board has N*N cells
//   W         cell width in bits, 2**W must exceed N
//   MAX_ERROS wrong moves that end the game (1..7)
//
// Ports
//   clk             system clock, rising edge
//   rstn            asynchronous reset, active low
//   start           evaluate one move (taken only in IDLE while unlocked)
//   novoJogo        synchronous new game: clears errors, lock and status,
//                   and aborts a move in flight
//   linha, coluna   1-based row / column of the move
//   valor           value to place
//   sudokuJogador   current player board, ascending, cell MSB at lowest index
//   sudokuCompleto  solution board, same layout, stable while busy
//   mascaraFixa     bit (l-1)*N+(c-1) set = given cell, not editable
//   novoSudoku      updated board, valid while enableRegSudoku=1
//   enableRegSudoku one-cycle write strobe to the board register
//   busy            a move is being processed
//   done            one-cycle pulse, saidaValor is final
//   saidaValor      000 none, 001 correct, 010 wrong, 011 rejected,
//                   101 win, 110 loss
//   erros           wrong moves so far
// -----------------------------------------------------------------------------
module verificador_jogada_n #(
  parameter int N         = 9,
  parameter int W         = 4,
  parameter int MAX_ERROS = 3
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               novoJogo,
  input  logic [3:0]         linha,
  input  logic [3:0]         coluna,
  input  logic [W-1:0]       valor,
  input  logic [0:N*N*W-1]   sudokuJogador,
  input  logic [0:N*N*W-1]   sudokuCompleto,
  input  logic [N*N-1:0]     mascaraFixa,
  output logic [0:N*N*W-1]   novoSudoku,
  output logic               enableRegSudoku,
  output logic               busy,
  output logic               done,
  output logic [2:0]         saidaValor,
  output logic [2:0]         erros
);

  localparam int CELLS = N * N;
  localparam int BITS  = N * N * W;
  localparam int ROWW  = N * W;
  // One spare bit over the largest bit index so that index arithmetic can
  // never wrap back into the board.
  localparam int IW    = $clog2(BITS) + 1;

  localparam logic [2:0] RES_NONE  = 3'b000;
  localparam logic [2:0] RES_OK    = 3'b001;
  localparam logic [2:0] RES_WRONG = 3'b010;
  localparam logic [2:0] RES_REJ   = 3'b011;
  localparam logic [2:0] RES_WIN   = 3'b101;
  localparam logic [2:0] RES_LOSS  = 3'b110;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    VALIDA  = 3'd1,
    ESCREVE = 3'd2,
    COMPARA = 3'd3,
    FIM     = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      lin_q, lin_d;
  logic [3:0]      col_q, col_d;
  logic [W-1:0]    val_q, val_d;
  logic [0:BITS-1] tab_q, tab_d;     // private copy of the board for this move
  logic [3:0]      r_q, r_d;         // row under comparison
  logic [2:0]      erros_q, erros_d;
  logic            lock_q, lock_d;
  logic [2:0]      saida_q, saida_d;

  // ---------------------------------------------------------------------------
  // Move decode. Bounds are checked on the raw 4-bit coordinates first; the
  // cell index is forced to 0 for illegal coordinates so an out-of-range move
  // can never select (or alias to) a real cell.
  // ---------------------------------------------------------------------------
  logic            coord_ok, val_ok;
  logic [IW-1:0]   cell_idx;
  logic            mask_sel;
  logic [W-1:0]    sol_sel;
  logic [0:BITS-1] tab_ins;

  assign coord_ok = (lin_q != 4'd0) && (lin_q <= 4'(N)) &&
                    (col_q != 4'd0) && (col_q <= 4'(N));
  assign val_ok   = (val_q != '0) && (val_q <= W'(N));

  assign cell_idx = coord_ok ?
                    ((IW'(lin_q) - IW'(1)) * IW'(N) + IW'(col_q) - IW'(1)) :
                    '0;

  // Cell select as a one-hot decode over all cells: picks the mask bit and
  // the solution value, and builds the board with the new value inserted.
  always_comb begin
    mask_sel = 1'b0;
    sol_sel  = '0;
    tab_ins  = tab_q;
    for (int k = 0; k < CELLS; k++) begin
      if (cell_idx == IW'(k)) begin
        mask_sel            = mascaraFixa[k];
        sol_sel             = sudokuCompleto[k*W +: W];
        tab_ins[k*W +: W]   = val_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-row equality of buffer vs solution. Padded to 16 entries with ones so
  // the 4-bit row counter indexes it directly.
  // ---------------------------------------------------------------------------
  logic [15:0] row_eq;

  for (genvar r = 0; r < 16; r++) begin : g_row
    if (r < N) begin : g_on
      assign row_eq[r] = (tab_q[r*ROWW +: ROWW] == sudokuCompleto[r*ROWW +: ROWW]);
    end else begin : g_off
      assign row_eq[r] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      lin_q   <= '0;
      col_q   <= '0;
      val_q   <= '0;
      tab_q   <= '0;
      r_q     <= '0;
      erros_q <= '0;
      lock_q  <= 1'b0;
      saida_q <= RES_NONE;
    end else begin
      state_q <= state_d;
      lin_q   <= lin_d;
      col_q   <= col_d;
      val_q   <= val_d;
      tab_q   <= tab_d;
      r_q     <= r_d;
      erros_q <= erros_d;
      lock_q  <= lock_d;
      saida_q <= saida_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    lin_d   = lin_q;
    col_d   = col_q;
    val_d   = val_q;
    tab_d   = tab_q;
    r_d     = r_q;
    erros_d = erros_q;
    lock_d  = lock_q;
    saida_d = saida_q;

    if (novoJogo) begin
      state_d = IDLE;
      erros_d = '0;
      lock_d  = 1'b0;
      saida_d = RES_NONE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !lock_q) begin
            lin_d   = linha;
            col_d   = coluna;
            val_d   = valor;
            tab_d   = sudokuJogador;
            state_d = VALIDA;
          end
        end

        VALIDA: begin
          if (!coord_ok || !val_ok || mask_sel) begin
            saida_d = RES_REJ;
            state_d = FIM;
          end else begin
            tab_d = tab_ins;
            if (sol_sel == val_q) begin
              state_d = ESCREVE;
            end else begin
              // The wrong value stays only in the private buffer and is
              // never presented on the write port.
              erros_d = erros_q + 3'd1;
              if (erros_d == 3'(MAX_ERROS)) begin
                saida_d = RES_LOSS;
                lock_d  = 1'b1;
              end else begin
                saida_d = RES_WRONG;
              end
              state_d = FIM;
            end
          end
        end

        ESCREVE: begin
          r_d     = '0;
          state_d = COMPARA;
        end

        COMPARA: begin
          if (!row_eq[r_q]) begin
            saida_d = RES_OK;
            state_d = FIM;
          end else if (r_q == 4'(N - 1)) begin
            saida_d = RES_WIN;
            lock_d  = 1'b1;
            state_d = FIM;
          end else begin
            r_d = r_q + 4'd1;
          end
        end

        FIM: begin
          state_d = IDLE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. novoJogo suppresses the strobe and done of an aborted move in
  // the same cycle it is raised.
  // ---------------------------------------------------------------------------
  assign enableRegSudoku = (state_q == ESCREVE) && !novoJogo;
  assign novoSudoku      = (state_q == ESCREVE) ? tab_q : '0;
  assign done            = (state_q == FIM) && !novoJogo;
  assign busy            = (state_q != IDLE);
  assign saidaValor      = saida_q;
  assign erros           = erros_q;

endmodule
